s2m_frame_ctrl: RTL and testbench
=================================

S2M_FRAME_CTRL -- requirements
Module: s2m_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one channel sample.
REQ-002 Parameter STRING_LEN, default 640: pixels per line.
REQ-003 Parameter STRING_NUM, default 480: lines per frame.
REQ-004 Parameter CHANNEL_NUM, default 3: channel samples per pixel, interleaved per beat.
REQ-005 Parameter LINE_GAP, default 16: mandatory idle cycles inserted after each line; legal range 1..255.
REQ-006 The clock port SHALL be clk, 1-bit input: the single clock.
REQ-007 The reset port SHALL be reset, 1-bit input: synchronous, active-high reset.
REQ-008 Port start_i, input, 1 bit: arms capture of one frame.
REQ-009 Port src_valid_i, input, 1 bit: source sample valid.
REQ-010 Port src_data_i, input, DATA_WIDTH bits: source sample.
REQ-011 Port src_ready_o, output, 1 bit: block accepts a sample this cycle.
REQ-012 Port data_valid_o, output, 1 bit: valid strobe to the window generator.
REQ-013 Port data_o, output, DATA_WIDTH bits: forwarded sample.
REQ-014 Ports sop_o, eop_o, sof_o, eof_o, outputs, 1 bit each: line and frame markers.
REQ-015 Port busy_o, output, 1 bit: a frame is in progress.
REQ-016 Port frame_done_o, output, 1 bit: one-cycle pulse when a frame completes.
REQ-017 Port err_o, output, 1 bit: sticky overrun flag (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, LINE, GAP and DONE.
REQ-019 IDLE -> LINE when start_i=1. LINE -> GAP on the accepted beat that completes a line. GAP -> LINE after LINE_GAP cycles if lines remain. GAP -> DONE after LINE_GAP cycles if the last line is done. DONE -> IDLE after one cycle.
REQ-020 src_ready_o SHALL be 1 only in LINE; a beat is accepted when src_valid_i and src_ready_o are both 1.
REQ-021 Counters SHALL be: chan_cnt 0..CHANNEL_NUM-1; pix_cnt 0..STRING_LEN-1, advancing on the beat where chan_cnt wraps; line_cnt 0..STRING_NUM-1, advancing on the beat where pix_cnt wraps. All three counters clear in IDLE.
REQ-022 Each accepted beat SHALL appear on data_o/data_valid_o exactly 1 cycle later; data_valid_o is 0 otherwise.
REQ-023 sop_o SHALL be 1 with the output of the first beat of each line (chan=0, pix=0).
REQ-024 eop_o SHALL be 1 with the output of the last beat of each line (chan=CHANNEL_NUM-1, pix=STRING_LEN-1).
REQ-025 sof_o SHALL equal sop_o AND line=0; eof_o SHALL equal eop_o AND line=STRING_NUM-1.
REQ-026 When STRING_LEN*CHANNEL_NUM=1, sop_o and eop_o SHALL assert on the same beat.
REQ-027 A GAP counter SHALL count 0..LINE_GAP-1; GAP exits on the cycle the count equals LINE_GAP-1.
REQ-028 frame_done_o SHALL be 1 only in DONE. busy_o SHALL be 1 in LINE, GAP and DONE.
REQ-029 start_i SHALL be ignored outside IDLE; start_i held high re-arms in the cycle after DONE.
REQ-030 src_valid_i gaps SHALL stall the counters without error while in LINE.

Reset
REQ-031 On reset=1 at a clock edge the FSM SHALL enter IDLE and clear all counters.
REQ-032 Reset values SHALL be 0 for src_ready_o, data_valid_o, data_o, sop_o, eop_o, sof_o, eof_o, busy_o, frame_done_o and err_o.
REQ-033 Reset mid-frame SHALL abandon the frame; no eof_o or frame_done_o SHALL follow.

Configuration
REQ-034 With macro S2M_FRAME_CTRL_OVERRUN_EN defined, err_o SHALL set when src_valid_i=1 while src_ready_o=0 and busy_o=1, and SHALL clear only on reset or on start_i accepted in IDLE.
REQ-035 Without the macro, err_o SHALL be constant 0 and no overrun logic SHALL be synthesized.

Verification
REQ-036 Scenario: STRING_LEN=4, STRING_NUM=2, CHANNEL_NUM=3, LINE_GAP=2; start pulse, then continuous valid -> 24 outputs; sop/eop at output beats 1, 12, 13 and 24; sof at beat 1; eof at beat 24; frame_done_o one cycle after the final GAP.
REQ-037 Scenario: same config with valid toggling every other cycle -> identical output sequence and markers, stretched in time; err_o=0.
REQ-038 Scenario: drive valid during GAP with the macro defined -> err_o=1 and sticky until the next start; without the macro -> err_o stays 0.
REQ-039 Scenario: reset asserted after 7 accepted beats -> all outputs 0 next cycle; the next start produces a fresh frame beginning with sof_o.
REQ-040 Scenario: start_i held high through two frames -> back-to-back frames with one IDLE cycle between, two frame_done_o pulses.
REQ-041 Scenario: STRING_LEN=1, CHANNEL_NUM=1, STRING_NUM=1 -> a single output beat with sop, eop, sof and eof all 1.

Source files
------------

// File: rtl/s2m_frame_ctrl_if.sv
// Handshake and marker bundle between the pixel source, s2m_frame_ctrl and the window generator.
// master: source / consumer side, slave: s2m_frame_ctrl side.
interface s2m_frame_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start_i;
   logic                  src_valid_i;
   logic [DATA_WIDTH-1:0] src_data_i;
   logic                  src_ready_o;
   logic                  data_valid_o;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  sop_o;
   logic                  eop_o;
   logic                  sof_o;
   logic                  eof_o;
   logic                  busy_o;
   logic                  frame_done_o;
   logic                  err_o;

   modport master (
      output start_i, src_valid_i, src_data_i,
      input  src_ready_o, data_valid_o, data_o, sop_o, eop_o, sof_o, eof_o,
      input  busy_o, frame_done_o, err_o
   );

   modport slave (
      input  start_i, src_valid_i, src_data_i,
      output src_ready_o, data_valid_o, data_o, sop_o, eop_o, sof_o, eof_o,
      output busy_o, frame_done_o, err_o
   );
endinterface

// File: rtl/s2m_frame_ctrl.sv
// Stream-to-memory frame controller: accepts one frame of interleaved samples, tags line/frame markers.
// Define S2M_FRAME_CTRL_OVERRUN_EN to enable the sticky overrun flag on err_o.
module s2m_frame_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int STRING_LEN  = 640,
   parameter int STRING_NUM  = 480,
   parameter int CHANNEL_NUM = 3,
   parameter int LINE_GAP    = 16
) (
   input logic              clk,
   input logic              reset,
   s2m_frame_ctrl_if.slave  bus
);
   localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
   localparam int PW = (STRING_LEN  > 1) ? $clog2(STRING_LEN)  : 1;
   localparam int LW = (STRING_NUM  > 1) ? $clog2(STRING_NUM)  : 1;
   localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNEL_NUM - 1);
   localparam logic [PW-1:0] LAST_PIX  = PW'(STRING_LEN - 1);
   localparam logic [LW-1:0] LAST_ROW  = LW'(STRING_NUM - 1);
   localparam logic [7:0]    LAST_GAP  = 8'(LINE_GAP - 1);

   typedef enum logic [1:0] {IDLE, LINE, GAP, DONE} state_t;

   state_t                state;
   logic [CW-1:0]         chan_cnt;
   logic [PW-1:0]         pix_cnt;
   logic [LW-1:0]         line_cnt;
   logic [7:0]            gap_cnt;
   logic                  last_line;
   logic [DATA_WIDTH-1:0] sample;
   logic                  accept;
   logic                  chan_wrap;
   logic                  pix_wrap;
   logic                  line_wrap;
   logic                  first_beat;
   logic                  last_beat;

   always_comb begin
      sample     = bus.src_data_i;
      accept     = bus.src_valid_i & bus.src_ready_o;
      chan_wrap  = (chan_cnt == LAST_CHAN);
      pix_wrap   = (pix_cnt == LAST_PIX);
      line_wrap  = (line_cnt == LAST_ROW);
      first_beat = (chan_cnt == '0) && (pix_cnt == '0);
      last_beat  = chan_wrap && pix_wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         chan_cnt         <= '0;
         pix_cnt          <= '0;
         line_cnt         <= '0;
         gap_cnt          <= '0;
         last_line        <= 1'b0;
         bus.src_ready_o  <= 1'b0;
         bus.data_valid_o <= 1'b0;
         bus.data_o       <= '0;
         bus.sop_o        <= 1'b0;
         bus.eop_o        <= 1'b0;
         bus.sof_o        <= 1'b0;
         bus.eof_o        <= 1'b0;
         bus.busy_o       <= 1'b0;
         bus.frame_done_o <= 1'b0;
      end else begin
         bus.data_valid_o <= 1'b0;
         bus.sop_o        <= 1'b0;
         bus.eop_o        <= 1'b0;
         bus.sof_o        <= 1'b0;
         bus.eof_o        <= 1'b0;
         case (state)
            IDLE: begin
               chan_cnt <= '0;
               pix_cnt  <= '0;
               line_cnt <= '0;
               if (bus.start_i) begin
                  state           <= LINE;
                  bus.src_ready_o <= 1'b1;
                  bus.busy_o      <= 1'b1;
               end
            end
            LINE: begin
               if (accept) begin
                  bus.data_valid_o <= 1'b1;
                  bus.data_o       <= sample;
                  bus.sop_o        <= first_beat;
                  bus.eop_o        <= last_beat;
                  bus.sof_o        <= first_beat && (line_cnt == '0);
                  bus.eof_o        <= last_beat && line_wrap;
                  // chan -> pix -> line cascade, each stage advances when the one below wraps
                  if (chan_wrap) begin
                     chan_cnt <= '0;
                     if (pix_wrap) begin
                        pix_cnt  <= '0;
                        line_cnt <= line_wrap ? '0 : line_cnt + 1'b1;
                     end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                     end
                  end else begin
                     chan_cnt <= chan_cnt + 1'b1;
                  end
                  if (last_beat) begin
                     state           <= GAP;
                     bus.src_ready_o <= 1'b0;
                     gap_cnt         <= '0;
                     last_line       <= line_wrap;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == LAST_GAP) begin
                  if (last_line) begin
                     state            <= DONE;
                     bus.frame_done_o <= 1'b1;
                  end else begin
                     state           <= LINE;
                     bus.src_ready_o <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            DONE: begin
               state            <= IDLE;
               bus.busy_o       <= 1'b0;
               bus.frame_done_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef S2M_FRAME_CTRL_OVERRUN_EN
   // source pushed data while a frame was running but the block was not ready
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.err_o <= 1'b0;
      end else if (state == IDLE && bus.start_i) begin
         bus.err_o <= 1'b0;
      end else if (bus.src_valid_i && !bus.src_ready_o && bus.busy_o) begin
         bus.err_o <= 1'b1;
      end
   end
`else
   assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_s2m_frame_ctrl.sv
// Randomized self-checking bench for s2m_frame_ctrl: a 4x2x3 frame instance and a 1x1x1 instance,
// both compared cycle by cycle against a beat-index reference model.
module tb_s2m_frame_ctrl;
   localparam int A_LEN = 4, A_NUM = 2, A_CH = 3, A_GAP = 2;
   localparam int B_LEN = 1, B_NUM = 1, B_CH = 1, B_GAP = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   s2m_frame_ctrl_if #(.DATA_WIDTH(8)) ia ();
   s2m_frame_ctrl_if #(.DATA_WIDTH(8)) ib ();

   s2m_frame_ctrl #(.DATA_WIDTH(8), .STRING_LEN(A_LEN), .STRING_NUM(A_NUM),
                    .CHANNEL_NUM(A_CH), .LINE_GAP(A_GAP))
      dut_a (.clk(clk), .reset(reset), .bus(ia));

   s2m_frame_ctrl #(.DATA_WIDTH(8), .STRING_LEN(B_LEN), .STRING_NUM(B_NUM),
                    .CHANNEL_NUM(B_CH), .LINE_GAP(B_GAP))
      dut_b (.clk(clk), .reset(reset), .bus(ib));

   typedef struct {
      int         phase;   // 0 idle, 1 frame running, 2 done cycle
      int         beats;
      int         hold;
      bit         ready, busy, done, err, dv, sop, eop, sof, eof;
      logic [7:0] data;
   } mdl_t;

   mdl_t ma, mb;
   int   n_chk = 0, n_pass = 0;

   int          a_out, a_done, b_out, b_done;
   logic [63:0] sop_m, eop_m, sof_m, eof_m;
   logic [3:0]  b_flags;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   // Frame seen as a flat sequence of beats: beat k is at line k/lb, position k%lb.
   task automatic mstep(inout mdl_t m, input int lb, input int nl, input int gap,
                        input bit rst, input bit start, input bit valid, input logic [7:0] din);
      int pos, ln;
      m.dv = 0; m.sop = 0; m.eop = 0; m.sof = 0; m.eof = 0;
`ifdef S2M_FRAME_CTRL_OVERRUN_EN
      if (rst) m.err = 0;
      else if (m.phase == 0 && start) m.err = 0;
      else if (valid && !m.ready && m.busy) m.err = 1;
`else
      m.err = 0;
`endif
      if (rst) begin
         m.phase = 0; m.beats = 0; m.hold = 0; m.data = 0;
      end else begin
         case (m.phase)
            0: if (start) begin m.phase = 1; m.beats = 0; m.hold = 0; end
            1: begin
               if (m.hold > 0) begin
                  m.hold--;
                  if (m.hold == 0 && m.beats == lb * nl) m.phase = 2;
               end else if (valid) begin
                  pos = m.beats % lb;
                  ln  = m.beats / lb;
                  m.dv = 1; m.data = din;
                  m.sop = (pos == 0);
                  m.eop = (pos == lb - 1);
                  m.sof = m.sop && ln == 0;
                  m.eof = m.eop && ln == nl - 1;
                  m.beats++;
                  if (m.eop) m.hold = gap;
               end
            end
            default: m.phase = 0;
         endcase
      end
      m.ready = (m.phase == 1 && m.hold == 0);
      m.busy  = (m.phase != 0);
      m.done  = (m.phase == 2);
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      forever begin
         @(posedge clk);
         mstep(ma, A_LEN * A_CH, A_NUM, A_GAP, reset, ia.start_i, ia.src_valid_i, ia.src_data_i);
         mstep(mb, B_LEN * B_CH, B_NUM, B_GAP, reset, ib.start_i, ib.src_valid_i, ib.src_data_i);
         #1;
         chk("a_ctl", {ia.src_ready_o, ia.data_valid_o, ia.busy_o, ia.frame_done_o, ia.err_o},
             {ma.ready, ma.dv, ma.busy, ma.done, ma.err});
         chk("a_mark", {ia.sop_o, ia.eop_o, ia.sof_o, ia.eof_o}, {ma.sop, ma.eop, ma.sof, ma.eof});
         if (ma.dv) chk("a_data", ia.data_o, ma.data);
         chk("b_ctl", {ib.src_ready_o, ib.data_valid_o, ib.busy_o, ib.frame_done_o, ib.err_o},
             {mb.ready, mb.dv, mb.busy, mb.done, mb.err});
         chk("b_mark", {ib.sop_o, ib.eop_o, ib.sof_o, ib.eof_o}, {mb.sop, mb.eop, mb.sof, mb.eof});
         if (mb.dv) chk("b_data", ib.data_o, mb.data);
         if (ia.data_valid_o) begin
            a_out++;
            if (a_out < 64) begin
               if (ia.sop_o) sop_m[a_out] = 1'b1;
               if (ia.eop_o) eop_m[a_out] = 1'b1;
               if (ia.sof_o) sof_m[a_out] = 1'b1;
               if (ia.eof_o) eof_m[a_out] = 1'b1;
            end
         end
         if (ia.frame_done_o) a_done++;
         if (ib.data_valid_o) begin
            b_out++;
            b_flags = {ib.sop_o, ib.eop_o, ib.sof_o, ib.eof_o};
         end
         if (ib.frame_done_o) b_done++;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         ia.src_data_i = 8'($urandom);
         ib.src_data_i = 8'($urandom);
      end
   end

   task automatic clr();
      a_out = 0; a_done = 0; b_out = 0; b_done = 0;
      sop_m = '0; eop_m = '0; sof_m = '0; eof_m = '0; b_flags = '0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_a();
      ia.start_i = 1'b1;
      cyc(1);
      ia.start_i = 1'b0;
   endtask

   function automatic logic [63:0] bits2(input int p, input int q);
      logic [63:0] v;
      v = '0;
      v[p] = 1'b1;
      v[q] = 1'b1;
      return v;
   endfunction

   task automatic check_frame(input string tag);
      chk({tag, "_nout"}, a_out, 24);
      chk({tag, "_sop"}, sop_m, bits2(1, 13));
      chk({tag, "_eop"}, eop_m, bits2(12, 24));
      chk({tag, "_sof"}, sof_m, bits2(1, 1));
      chk({tag, "_eof"}, eof_m, bits2(24, 24));
      chk({tag, "_done"}, a_done, 1);
   endtask

   initial begin
      reset = 1'b1;
      ia.start_i = 0; ia.src_valid_i = 0; ia.src_data_i = 0;
      ib.start_i = 0; ib.src_valid_i = 0; ib.src_data_i = 0;
      clr();
      cyc(3);
      chk("rst_a", {ia.src_ready_o, ia.data_valid_o, ia.data_o, ia.sop_o, ia.eop_o, ia.sof_o,
                    ia.eof_o, ia.busy_o, ia.frame_done_o, ia.err_o}, 0);
      chk("rst_b", {ib.src_ready_o, ib.data_valid_o, ib.data_o, ib.sop_o, ib.eop_o, ib.sof_o,
                    ib.eof_o, ib.busy_o, ib.frame_done_o, ib.err_o}, 0);
      reset = 1'b0;
      cyc(2);

      // continuous valid
      clr();
      ia.src_valid_i = 1'b1;
      start_a();
      cyc(40);
      ia.src_valid_i = 1'b0;
      check_frame("cont");
      cyc(3);

      // valid toggling every other cycle
      clr();
      start_a();
      for (int i = 0; i < 90; i++) begin
         ia.src_valid_i = ~ia.src_valid_i;
         cyc(1);
      end
      ia.src_valid_i = 1'b0;
      check_frame("tog");
      chk("tog_err", ia.err_o, ma.err);
      cyc(3);

      // valid held through a gap: overrun flag behaviour
      clr();
      ia.src_valid_i = 1'b1;
      start_a();
      cyc(16);
      ia.src_valid_i = 1'b0;
`ifdef S2M_FRAME_CTRL_OVERRUN_EN
      chk("ovr_err_set", ia.err_o, 1);
      cyc(30);
      chk("ovr_err_sticky", ia.err_o, 1);
      start_a();
      cyc(1);
      chk("ovr_err_clr", ia.err_o, 0);
      cyc(40);
`else
      chk("ovr_err_off", ia.err_o, 0);
      cyc(30);
`endif
      cyc(3);

      // reset after 7 accepted beats
      clr();
      start_a();
      for (int i = 0; i < 300 && a_out < 7; i++) begin
         ia.src_valid_i = ($urandom_range(0, 9) < 6);
         cyc(1);
      end
      chk("rst7_reach", a_out, 7);
      ia.src_valid_i = 1'b0;
      reset = 1'b1;
      cyc(1);
      chk("rst7_out", {ia.src_ready_o, ia.data_valid_o, ia.data_o, ia.sop_o, ia.eop_o, ia.sof_o,
                       ia.eof_o, ia.busy_o, ia.frame_done_o, ia.err_o}, 0);
      reset = 1'b0;
      cyc(30);
      chk("rst7_nodone", a_done, 0);
      chk("rst7_noeof", eof_m, 0);
      clr();
      ia.src_valid_i = 1'b1;
      start_a();
      cyc(40);
      ia.src_valid_i = 1'b0;
      check_frame("fresh");
      cyc(3);

      // start held high: two back-to-back frames
      clr();
      ia.start_i = 1'b1;
      ia.src_valid_i = 1'b1;
      cyc(35);
      ia.start_i = 1'b0;
      cyc(40);
      ia.src_valid_i = 1'b0;
      chk("b2b_done", a_done, 2);
      chk("b2b_nout", a_out, 48);
      chk("b2b_sof", sof_m, bits2(1, 25));
      chk("b2b_eof", eof_m, bits2(24, 48));
      cyc(3);

      // single-beat frame
      clr();
      ib.src_valid_i = 1'b1;
      ib.start_i = 1'b1;
      cyc(1);
      ib.start_i = 1'b0;
      cyc(10);
      ib.src_valid_i = 1'b0;
      chk("one_nout", b_out, 1);
      chk("one_flags", b_flags, 4'b1111);
      chk("one_done", b_done, 1);
      cyc(3);

      // random mix on both instances
      for (int i = 0; i < 600; i++) begin
         ia.start_i     = ($urandom_range(0, 19) == 0);
         ia.src_valid_i = ($urandom_range(0, 9) < 6);
         ib.start_i     = ($urandom_range(0, 7) == 0);
         ib.src_valid_i = ($urandom_range(0, 9) < 5);
         reset          = ($urandom_range(0, 249) == 0);
         cyc(1);
      end
      reset = 1'b0;
      ia.start_i = 0; ia.src_valid_i = 0;
      ib.start_i = 0; ib.src_valid_i = 0;
      cyc(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
